// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the non-load CDB; combinational grant, winner registered onto the CDB (1-cycle latency).
// Backpressure: ena low holds the broadcast and ptr with no grant; flush clears both and outranks the stall.
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        in_flush,
    input  logic [NUM_SRC-1:0]          in_req_valid,
    input  logic [NUM_SRC*TAG_W-1:0]    in_req_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   in_req_value,
    input  logic [NUM_SRC-1:0]          in_req_isjump,
    input  logic [NUM_SRC*DATA_W-1:0]   in_req_jump_addr,
    output logic [NUM_SRC-1:0]          out_req_ready,
    output logic [TAG_W-1:0]            out_cdb_rob_tag,
    output logic [DATA_W-1:0]           out_cdb_value,
    output logic                        out_cdb_isjump,
    output logic [DATA_W-1:0]           out_cdb_jump_addr
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              isjump;
        logic [DATA_W-1:0] jump_addr;
    } cdb_t;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W:0]     idx;
    logic [NUM_SRC-1:0] eligible;
    logic               found;
    logic               grant_en;
    cdb_t               sel;
    cdb_t               cdb;

    // Tag 0 is the ROB's "no broadcast" marker, so such requests never compete.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++)
            eligible[i] = in_req_valid[i] && (in_req_tag[i*TAG_W +: TAG_W] != '0);
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_SRC))
                idx = idx - (PTR_W+1)'(NUM_SRC);
            if (!found && eligible[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    assign grant_en = rst && ena && !in_flush && found;
    assign ptr_nxt  = (winner == PTR_W'(NUM_SRC-1)) ? '0 : winner + 1'b1;

    always_comb begin
        out_req_ready = '0;
        sel           = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            out_req_ready[i] = grant_en && (winner == PTR_W'(i));
            if (winner == PTR_W'(i)) begin
                sel.tag       = in_req_tag[i*TAG_W +: TAG_W];
                sel.value     = in_req_value[i*DATA_W +: DATA_W];
                sel.isjump    = in_req_isjump[i];
                sel.jump_addr = in_req_jump_addr[i*DATA_W +: DATA_W];
            end
        end
    end

    // Idle enabled edges load zeros so each broadcast lasts exactly one enabled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb <= '0;
            ptr <= '0;
        end else if (in_flush) begin
            cdb <= '0;
            ptr <= '0;
        end else if (ena) begin
            if (found) begin
                cdb <= sel;
                ptr <= ptr_nxt;
            end else begin
                cdb <= '0;
            end
        end
    end

    assign out_cdb_rob_tag   = cdb.tag;
    assign out_cdb_value     = cdb.value;
    assign out_cdb_isjump    = cdb.isjump;
    assign out_cdb_jump_addr = cdb.jump_addr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand-written corner sequences, randomized run against a reference model.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        in_flush = 1'b0;
    logic [2:0]  in_req_valid = '0;
    logic [14:0] in_req_tag = '0;
    logic [95:0] in_req_value = '0;
    logic [2:0]  in_req_isjump = '0;
    logic [95:0] in_req_jump_addr = '0;
    logic [2:0]  out_req_ready;
    logic [4:0]  out_cdb_rob_tag;
    logic [31:0] out_cdb_value;
    logic        out_cdb_isjump;
    logic [31:0] out_cdb_jump_addr;

    int vectors = 0;
    int miscompares = 0;

    cdb_arbiter #(.NUM_SRC(3), .TAG_W(5), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .ena               (ena),
        .in_flush          (in_flush),
        .in_req_valid      (in_req_valid),
        .in_req_tag        (in_req_tag),
        .in_req_value      (in_req_value),
        .in_req_isjump     (in_req_isjump),
        .in_req_jump_addr  (in_req_jump_addr),
        .out_req_ready     (out_req_ready),
        .out_cdb_rob_tag   (out_cdb_rob_tag),
        .out_cdb_value     (out_cdb_value),
        .out_cdb_isjump    (out_cdb_isjump),
        .out_cdb_jump_addr (out_cdb_jump_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ena;
        logic       flush;
        logic [2:0] valid;
        logic [4:0] t0, t1, t2;
        logic [2:0] exp_rdy;
        logic [4:0] exp_tag;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input int e, input int f, input int v, input int t0, input int t1,
                       input int t2, input int r, input int t);
        vec_t x;
        x.ena = 1'(e); x.flush = 1'(f); x.valid = 3'(v);
        x.t0 = 5'(t0); x.t1 = 5'(t1); x.t2 = 5'(t2);
        x.exp_rdy = 3'(r); x.exp_tag = 5'(t);
        tbl.push_back(x);
    endtask

    // Table payloads are derived from the tag so the whole broadcast can be predicted.
    function automatic logic [31:0] pv(input logic [4:0] t);
        return 32'hA5A5_0000 | 32'(t);
    endfunction
    function automatic logic [31:0] pa(input logic [4:0] t);
        return 32'(t) << 2;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [4:0] t, input logic [31:0] v,
                           input logic j, input logic [31:0] a);
        check({nm, "_tag"}, 32'(out_cdb_rob_tag), 32'(t));
        check({nm, "_value"}, out_cdb_value, v);
        check({nm, "_isjump"}, 32'(out_cdb_isjump), 32'(j));
        check({nm, "_jaddr"}, out_cdb_jump_addr, a);
    endtask

    task automatic set_src(input int i, input logic v, input logic [4:0] t, input logic [31:0] val,
                           input logic ij, input logic [31:0] ja);
        in_req_valid[i]            = v;
        in_req_tag[i*5 +: 5]       = t;
        in_req_value[i*32 +: 32]   = val;
        in_req_isjump[i]           = ij;
        in_req_jump_addr[i*32 +: 32] = ja;
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 3; i++) set_src(i, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [4:0]  rt[3];
        logic [31:0] rvl[3];
        logic [31:0] rja[3];
        logic        rv[3];
        logic        rij[3];
        logic        ren, rfl;
        logic [4:0]  m_tag;
        logic [31:0] m_val, m_ja;
        logic        m_ij;
        int          m_ptr;
        int          w;
        logic [2:0]  er;

        row(1,1,3'b000, 0, 0, 0, 3'b000, 0);
        row(1,0,3'b111, 1, 2, 3, 3'b001, 1);
        row(1,0,3'b110, 1, 2, 3, 3'b010, 2);
        row(1,0,3'b100, 1, 2, 3, 3'b100, 3);
        row(1,0,3'b101, 6, 0, 8, 3'b001, 6);
        row(1,0,3'b100, 6, 0, 8, 3'b100, 8);
        row(1,0,3'b001, 4, 0, 0, 3'b001, 4);
        row(0,0,3'b010, 4,10, 0, 3'b000, 4);
        row(0,0,3'b010, 4,10, 0, 3'b000, 4);
        row(1,0,3'b010, 4,10, 0, 3'b010,10);
        row(1,0,3'b000, 0, 0, 0, 3'b000, 0);
        row(1,0,3'b100, 0, 0, 9, 3'b100, 9);
        row(1,1,3'b011,11,12, 0, 3'b000, 0);
        row(1,0,3'b011,11,12, 0, 3'b001,11);
        row(1,0,3'b010,11,12, 0, 3'b010,12);
        row(1,0,3'b011, 0, 5, 0, 3'b010, 5);
        row(1,0,3'b001,13, 0, 0, 3'b001,13);
        row(0,1,3'b010, 0,14, 0, 3'b000, 0);
        row(1,0,3'b011,15,14, 0, 3'b001,15);
        row(1,0,3'b001, 0, 0, 0, 3'b000, 0);

        // Reset held, then released with no requests.
        repeat (3) begin
            @(negedge clk); #2;
            check("reset_rdy", 32'(out_req_ready), 32'd0);
            chk_out("reset", 5'd0, 32'd0, 1'b0, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;
        repeat (2) begin
            @(negedge clk); #2;
            check("idle_rdy", 32'(out_req_ready), 32'd0);
            @(posedge clk); #1;
            chk_out("idle", 5'd0, 32'd0, 1'b0, 32'd0);
        end

        // Single request from source 1.
        @(negedge clk);
        set_src(1, 1'b1, 5'd7, 32'h1234, 1'b1, 32'h80);
        #2 check("single_rdy", 32'(out_req_ready), 32'b010);
        @(posedge clk); #1;
        chk_out("single", 5'd7, 32'h1234, 1'b1, 32'h80);
        @(negedge clk);
        clear_srcs();
        #2 check("single_after_rdy", 32'(out_req_ready), 32'd0);
        @(posedge clk); #1;
        chk_out("single_after", 5'd0, 32'd0, 1'b0, 32'd0);

        // Directed table: round-robin, stall, flush, tag zero.
        for (int n = 0; n < tbl.size(); n++) begin
            @(negedge clk);
            ena      = tbl[n].ena;
            in_flush = tbl[n].flush;
            set_src(0, tbl[n].valid[0], tbl[n].t0, pv(tbl[n].t0), tbl[n].t0[0], pa(tbl[n].t0));
            set_src(1, tbl[n].valid[1], tbl[n].t1, pv(tbl[n].t1), tbl[n].t1[0], pa(tbl[n].t1));
            set_src(2, tbl[n].valid[2], tbl[n].t2, pv(tbl[n].t2), tbl[n].t2[0], pa(tbl[n].t2));
            #2 check($sformatf("row%0d_rdy", n), 32'(out_req_ready), 32'(tbl[n].exp_rdy));
            @(posedge clk); #1;
            if (tbl[n].exp_tag == 5'd0)
                chk_out($sformatf("row%0d", n), 5'd0, 32'd0, 1'b0, 32'd0);
            else
                chk_out($sformatf("row%0d", n), tbl[n].exp_tag, pv(tbl[n].exp_tag),
                        tbl[n].exp_tag[0], pa(tbl[n].exp_tag));
        end

        // Asynchronous reset in the middle of a broadcast cycle.
        @(negedge clk);
        ena = 1'b1;
        in_flush = 1'b0;
        clear_srcs();
        set_src(1, 1'b1, 5'd5, pv(5'd5), 1'b1, pa(5'd5));
        #2 check("arst_pre_rdy", 32'(out_req_ready), 32'b010);
        @(posedge clk); #1;
        chk_out("arst_pre", 5'd5, pv(5'd5), 1'b1, pa(5'd5));
        #1 rst = 1'b0;
        #1 check("arst_rdy", 32'(out_req_ready), 32'd0);
        chk_out("arst", 5'd0, 32'd0, 1'b0, 32'd0);
        clear_srcs();
        @(negedge clk);
        rst = 1'b1;

        // Randomized run against the reference model.
        m_ptr = 0; m_tag = '0; m_val = '0; m_ij = 1'b0; m_ja = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            ren = ($urandom_range(0, 7) != 0);
            rfl = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 3; i++) begin
                rv[i]  = ($urandom_range(0, 3) != 0);
                rt[i]  = 5'($urandom_range(0, 6));
                rvl[i] = $urandom;
                rij[i] = 1'($urandom_range(0, 1));
                rja[i] = $urandom;
                set_src(i, rv[i], rt[i], rvl[i], rij[i], rja[i]);
            end
            ena = ren;
            in_flush = rfl;
            w = -1;
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_ptr + k) % 3;
                if (w < 0 && rv[i] && rt[i] != 0) w = i;
            end
            er = (ren && !rfl && w >= 0) ? 3'(1 << w) : 3'b000;
            #2 check($sformatf("rand%0d_rdy", c), 32'(out_req_ready), 32'(er));
            @(posedge clk); #1;
            if (rfl) begin
                m_tag = '0; m_val = '0; m_ij = 1'b0; m_ja = '0; m_ptr = 0;
            end else if (ren) begin
                if (w >= 0) begin
                    m_tag = rt[w]; m_val = rvl[w]; m_ij = rij[w]; m_ja = rja[w];
                    m_ptr = (w + 1) % 3;
                end else begin
                    m_tag = '0; m_val = '0; m_ij = 1'b0; m_ja = '0;
                end
            end
            chk_out($sformatf("rand%0d", c), m_tag, m_val, m_ij, m_ja);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
